// File: rtl/p601_mem_pkg.sv
// ---------------------------------------------------------------------------
// p601_mem_pkg
//   Shared definitions for the external SRAM arbiter and its address mapper.
//   Contents:
//     EXT_AW      external SRAM address width (128K x 8)
//     PAGE_WIN    CPU address[15:13] value that selects the paged window
//     arb_state_e access sequencer states
//     owner_e     owner of the access in flight
// ---------------------------------------------------------------------------
package p601_mem_pkg;

    localparam int unsigned EXT_AW   = 17;
    localparam logic [2:0]  PAGE_WIN = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VPU = 1'b1
    } owner_e;

endpackage

// File: rtl/sram_addr_map.sv
// ---------------------------------------------------------------------------
// sram_addr_map
//   Combinational CPU address / page-window mapper. CPU addresses in
//   $C000-$DFFF are redirected into bank 1 using mempage[2:0] when the window
//   is enabled. Writes to a write-protected window fall through to bank 0
//   (the shadow copy) instead.
//   Ports:
//     cpu_addr   in   16  CPU address
//     mempage    in   5   [2:0] page, [3] window enable, [4] window write-protect
//     cpu_write  in   1   1 = the access is a write
//     ext_addr   out  17  mapped SRAM address
// ---------------------------------------------------------------------------
module sram_addr_map
    import p601_mem_pkg::*;
(
    input  logic [15:0]       cpu_addr,
    input  logic [4:0]        mempage,
    input  logic              cpu_write,
    output logic [EXT_AW-1:0] ext_addr
);

    always_comb begin
        if ((cpu_addr[15:13] == PAGE_WIN) && mempage[3] && !(mempage[4] && cpu_write)) begin
            ext_addr = {1'b1, mempage[2:0], cpu_addr[12:0]};
        end else begin
            ext_addr = {1'b0, cpu_addr};
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares the single external 128Kx8 SRAM between the CPU and the VPU video
//   fetch. Each access runs IDLE -> ADDR -> STROBE (WAIT_STATES+1 clk) ->
//   RECOVER -> IDLE; the owner is acked during RECOVER. The VPU has priority
//   but may take at most VPU_RUN_MAX consecutive grants while the CPU waits.
//   Optional feature macro: SRAM_ARB_STATS_EN (adds a CPU stall counter).
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     cpu_req/rw/addr/wdata      CPU request (level, held until cpu_ack)
//     mempage                    page-window control for CPU accesses
//     cpu_rdata/cpu_ack/cpu_hold CPU completion, read data, stall request
//     vpu_req/vpu_addr           VPU fetch request (bank 0 only)
//     vpu_rdata/vpu_ack          VPU completion and fetched byte
//     stats_clr/cpu_stall_cnt    (SRAM_ARB_STATS_EN only) stall statistics
//     EXT_AD/EXT_DQ/EXT_OE_n/EXT_WE_n/SRAM_CS2  SRAM pins
// ---------------------------------------------------------------------------
module sram_arbiter
    import p601_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned VPU_RUN_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic [4:0]        mempage,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_hold,
    input  logic              vpu_req,
    input  logic [15:0]       vpu_addr,
    output logic [7:0]        vpu_rdata,
    output logic              vpu_ack,
`ifdef SRAM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       cpu_stall_cnt,
`endif
    output logic [EXT_AW-1:0] EXT_AD,
    inout  wire  [7:0]        EXT_DQ,
    output logic              EXT_OE_n,
    output logic              EXT_WE_n,
    output logic              SRAM_CS2
);

    localparam int unsigned WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned RCW = (VPU_RUN_MAX > 0) ? $clog2(VPU_RUN_MAX + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_STATES);
    localparam logic [RCW-1:0] RUN_MAX   = RCW'(VPU_RUN_MAX);

    arb_state_e        state_q, state_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [RCW-1:0]    run_cnt_q, run_cnt_d;
    owner_e            owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [EXT_AW-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              mask_q, mask_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        vpu_rdata_q, vpu_rdata_d;

    logic [EXT_AW-1:0] cpu_map_addr;
    logic              vpu_wins, cpu_wins, winner_masked;
    logic              grant_vpu, grant_cpu;
    logic              dq_oe;

    sram_addr_map u_map (
        .cpu_addr  (cpu_addr),
        .mempage   (mempage),
        .cpu_write (~cpu_rw),
        .ext_addr  (cpu_map_addr)
    );

    // Winner is chosen on the raw requests; if that winner is the requester
    // acked in the previous RECOVER, its req is stale, so the IDLE cycle
    // grants nothing rather than handing the slot to the loser.
    always_comb begin : arbitrate
        vpu_wins      = vpu_req && !(cpu_req && (run_cnt_q == RUN_MAX));
        cpu_wins      = cpu_req && !vpu_wins;
        winner_masked = mask_q && ((vpu_wins && (owner_q == OWN_VPU)) ||
                                   (cpu_wins && (owner_q == OWN_CPU)));
        grant_vpu     = (state_q == ST_IDLE) && vpu_wins && !winner_masked;
        grant_cpu     = (state_q == ST_IDLE) && cpu_wins && !winner_masked;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            run_cnt_q   <= '0;
            owner_q     <= OWN_CPU;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= 1'b0;
            cpu_rdata_q <= '0;
            vpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            run_cnt_q   <= run_cnt_d;
            owner_q     <= owner_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cpu_rdata_q <= cpu_rdata_d;
            vpu_rdata_q <= vpu_rdata_d;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        run_cnt_d   = run_cnt_q;
        owner_d     = owner_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vpu_rdata_d = vpu_rdata_q;
        mask_d      = (state_q == ST_RECOVER);

        case (state_q)
            ST_IDLE: begin
                if (grant_vpu) begin
                    state_d    = ST_ADDR;
                    owner_d    = OWN_VPU;
                    rw_d       = 1'b1;
                    addr_d     = {1'b0, vpu_addr};
                    wait_cnt_d = '0;
                end else if (grant_cpu) begin
                    state_d    = ST_ADDR;
                    owner_d    = OWN_CPU;
                    rw_d       = cpu_rw;
                    addr_d     = cpu_map_addr;
                    wdata_d    = cpu_wdata;
                    wait_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                state_d    = ST_STROBE;
                wait_cnt_d = '0;
            end
            ST_STROBE: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RECOVER;
                    if (rw_q) begin
                        if (owner_q == OWN_VPU) vpu_rdata_d = EXT_DQ;
                        else                    cpu_rdata_d = EXT_DQ;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (!cpu_req || grant_cpu) begin
            run_cnt_d = '0;
        end else if (grant_vpu && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + RCW'(1);
        end
    end

    always_comb begin : outputs
        SRAM_CS2  = (state_q != ST_IDLE);
        EXT_OE_n  = !((state_q == ST_STROBE) && rw_q);
        EXT_WE_n  = !((state_q == ST_STROBE) && !rw_q);
        dq_oe     = (state_q == ST_STROBE) && !rw_q;
        cpu_ack   = (state_q == ST_RECOVER) && (owner_q == OWN_CPU);
        vpu_ack   = (state_q == ST_RECOVER) && (owner_q == OWN_VPU);
        cpu_hold  = cpu_req && !cpu_ack;
        EXT_AD    = addr_q;
        cpu_rdata = cpu_rdata_q;
        vpu_rdata = vpu_rdata_q;
    end

    assign EXT_DQ = dq_oe ? wdata_q : 8'hzz;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stats_clr) begin
            stall_cnt_d = '0;
        end else if (cpu_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int unsigned WS      = 1;
    localparam int unsigned RUN_MAX = 4;
    localparam int unsigned ACK_LAT = WS + 3;
    localparam int unsigned STB_LEN = WS + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [4:0]  mempage;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, cpu_hold;
    logic        vpu_req;
    logic [15:0] vpu_addr;
    logic [7:0]  vpu_rdata;
    logic        vpu_ack;
    logic [16:0] EXT_AD;
    wire  [7:0]  EXT_DQ;
    logic        EXT_OE_n, EXT_WE_n, SRAM_CS2;
`ifdef SRAM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cpu_stall_cnt;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_STATES(WS), .VPU_RUN_MAX(RUN_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mempage(mempage), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
        .vpu_req(vpu_req), .vpu_addr(vpu_addr), .vpu_rdata(vpu_rdata), .vpu_ack(vpu_ack),
`ifdef SRAM_ARB_STATS_EN
        .stats_clr(stats_clr), .cpu_stall_cnt(cpu_stall_cnt),
`endif
        .EXT_AD(EXT_AD), .EXT_DQ(EXT_DQ), .EXT_OE_n(EXT_OE_n), .EXT_WE_n(EXT_WE_n),
        .SRAM_CS2(SRAM_CS2)
    );

    // SRAM model: unwritten locations return a fixed address pattern,
    // written locations are kept in a small log (latest entry wins).
    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
    endfunction

    int          wr_n = 0;
    logic [16:0] wr_a [32];
    logic [7:0]  wr_d [32];
    logic [7:0]  sram_q;

    always @(posedge clk) begin
        if (SRAM_CS2 && !EXT_WE_n && wr_n < 32) begin
            wr_a[wr_n] <= EXT_AD;
            wr_d[wr_n] <= EXT_DQ;
            wr_n       <= wr_n + 1;
        end
    end

    always_comb begin
        sram_q = pat(EXT_AD);
        for (int i = 0; i < 32; i++)
            if (i < wr_n && wr_a[i] == EXT_AD) sram_q = wr_d[i];
    end

    assign EXT_DQ = (SRAM_CS2 && !EXT_OE_n) ? sram_q : 8'hzz;

    function automatic logic [7:0] sram_peek(input logic [16:0] a);
        logic [7:0] r = pat(a);
        for (int i = 0; i < 32; i++)
            if (i < wr_n && wr_a[i] == a) r = wr_d[i];
        return r;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic        rd;
        logic [16:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        vpu_q[$];
    byte         ack_order[$];
    int          strb_len = 0;
    logic [16:0] strb_addr = '0;
    logic        strb_wr = 1'b0;

    task automatic check_done(input string who, input exp_t e, input logic [7:0] rdata);
        chk({who, "_strobe_addr"}, 32'(strb_addr), 32'(e.addr));
        chk({who, "_strobe_len"},  32'(strb_len),  32'(STB_LEN));
        chk({who, "_strobe_kind"}, 32'(strb_wr),   32'(!e.rd));
        if (e.rd) chk({who, "_rdata"}, 32'(rdata), 32'(e.data));
        else      chk({who, "_sram_written"}, 32'(sram_peek(e.addr)), 32'(e.data));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            strb_len = 0;
        end else begin
            if (!EXT_OE_n || !EXT_WE_n) begin
                strb_len++;
                strb_addr = EXT_AD;
                strb_wr   = !EXT_WE_n;
            end
            if (cpu_ack) begin
                ack_order.push_back("C");
                chk("cpu_hold_on_ack", 32'(cpu_hold), 32'(0));
                if (cpu_q.size() == 0) chk("cpu_ack_expected", 32'(cpu_q.size()), 32'(1));
                else check_done("cpu", cpu_q.pop_front(), cpu_rdata);
                strb_len = 0;
            end
            if (vpu_ack) begin
                ack_order.push_back("V");
                if (cpu_req) chk("cpu_hold_during_vpu", 32'(cpu_hold), 32'(1));
                if (vpu_q.size() == 0) chk("vpu_ack_expected", 32'(vpu_q.size()), 32'(1));
                else check_done("vpu", vpu_q.pop_front(), vpu_rdata);
                strb_len = 0;
            end
        end
    end

    // Vector table
    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [4:0]  page;
        logic [16:0] exp_ad;
        logic [7:0]  exp_d;
        logic        pert;
    } vec_t;

    vec_t vecs[10];

    task automatic cpu_access(input vec_t v, input string tag);
        exp_t e;
        int   cs2_k = 0;
        int   ack_k = 0;
        e.rd   = v.rw;
        e.addr = v.exp_ad;
        e.data = v.exp_d;
        cpu_q.push_back(e);
        #1;
        cpu_req = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr; cpu_wdata = v.wdata; mempage = v.page;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (SRAM_CS2 && cs2_k == 0) cs2_k = k;
            if (k == 2) chk({tag, "_hold_wait"}, 32'(cpu_hold), 32'(1));
            if (cpu_ack) begin
                ack_k = k;
                break;
            end
            if (k == 1 && v.pert) begin
                #1;
                cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; mempage = ~v.page; cpu_rw = ~v.rw;
            end
        end
        chk({tag, "_cs2_delay"}, 32'(cs2_k), 32'(1));
        chk({tag, "_ack_latency"}, 32'(ack_k), 32'(ACK_LAT));
        #1 cpu_req = 1'b0;
        @(negedge clk);
        if (v.rw) chk({tag, "_rdata_held"}, 32'(cpu_rdata), 32'(v.exp_d));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_ord;
        exp_t  e;
        int    acks;
        int    ack_k;
        logic  found;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        mempage = '0; vpu_req = 1'b0; vpu_addr = '0;
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        vecs[0] = '{1'b1, 16'h1234, 8'h00, 5'b00000, 17'h01234, pat(17'h01234), 1'b0};
        vecs[1] = '{1'b0, 16'hC010, 8'hAA, 5'b01101, 17'h1A010, 8'hAA,          1'b1};
        vecs[2] = '{1'b0, 16'hC010, 8'h55, 5'b11101, 17'h0C010, 8'h55,          1'b0};
        vecs[3] = '{1'b1, 16'hC010, 8'h00, 5'b01101, 17'h1A010, 8'hAA,          1'b0};
        vecs[4] = '{1'b1, 16'hC010, 8'h00, 5'b11101, 17'h1A010, 8'hAA,          1'b0};
        vecs[5] = '{1'b1, 16'hDFFF, 8'h00, 5'b01011, 17'h17FFF, pat(17'h17FFF), 1'b0};
        vecs[6] = '{1'b1, 16'hE000, 8'h00, 5'b01011, 17'h0E000, pat(17'h0E000), 1'b0};
        vecs[7] = '{1'b1, 16'hBFFF, 8'h00, 5'b01111, 17'h0BFFF, pat(17'h0BFFF), 1'b0};
        vecs[8] = '{1'b1, 16'hC000, 8'h00, 5'b00111, 17'h0C000, pat(17'h0C000), 1'b0};
        vecs[9] = '{1'b1, 16'hC010, 8'h00, 5'b00000, 17'h0C010, 8'h55,          1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_oe_n", 32'(EXT_OE_n), 32'(1));
        chk("rst_we_n", 32'(EXT_WE_n), 32'(1));
        chk("rst_cs2",  32'(SRAM_CS2), 32'(0));
        chk("rst_ad",   32'(EXT_AD),   32'(0));
        chk("rst_acks", 32'({cpu_ack, vpu_ack}), 32'(0));
        chk("rst_rdata", 32'({cpu_rdata, vpu_rdata}), 32'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);

`ifdef SRAM_ARB_STATS_EN
        chk("stats_reset", 32'(cpu_stall_cnt), 32'(0));
`endif

        // Table-driven CPU accesses
        foreach (vecs[i]) cpu_access(vecs[i], $sformatf("vec%0d", i));

`ifdef SRAM_ARB_STATS_EN
        #1 stats_clr = 1'b1;
        @(negedge clk);
        #1 stats_clr = 1'b0;
        chk("stats_clr", 32'(cpu_stall_cnt), 32'(0));
        cpu_access(vecs[0], "stats_acc");
        chk("stats_count", 32'(cpu_stall_cnt), 32'(ACK_LAT));
        #1 stats_clr = 1'b1;
        @(negedge clk);
        #1 stats_clr = 1'b0;
        chk("stats_clr2", 32'(cpu_stall_cnt), 32'(0));
`endif

        // Both requesters held: VPU run limit forces a CPU slot
        e = '{1'b1, 17'h00100, pat(17'h00100)};
        repeat (2 * RUN_MAX) vpu_q.push_back(e);
        e = '{1'b1, 17'h02000, pat(17'h02000)};
        repeat (2) cpu_q.push_back(e);
        ack_order.delete();
        #1;
        vpu_req = 1'b1; vpu_addr = 16'h0100;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h2000; mempage = 5'b00000;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            #1;
            if (ack_order.size() >= 2 * (RUN_MAX + 1)) break;
        end
        vpu_req = 1'b0; cpu_req = 1'b0;
        chk("order_count", 32'(ack_order.size()), 32'(2 * (RUN_MAX + 1)));
        exp_ord = "VVVVCVVVVC";
        for (int i = 0; i < 10; i++)
            if (i < ack_order.size())
                chk($sformatf("order_%0d", i), 32'(ack_order[i]), 32'(exp_ord[i]));
        repeat (2) @(negedge clk);

        // VPU drops req and changes address right after grant
        vpu_q.push_back('{1'b1, 17'h0ABCD, pat(17'h0ABCD)});
        #1 vpu_req = 1'b1; vpu_addr = 16'hABCD;
        ack_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (vpu_ack) begin
                ack_k = k;
                break;
            end
            if (k == 1) begin
                #1 vpu_req = 1'b0; vpu_addr = 16'h5555;
            end
        end
        chk("vpu_drop_ack_latency", 32'(ack_k), 32'(ACK_LAT));
        @(negedge clk);
        chk("vpu_rdata_held", 32'(vpu_rdata), 32'(pat(17'h0ABCD)));
        @(negedge clk);

        // Reset during a write strobe
        #1 cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 8'h77; mempage = '0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!EXT_WE_n) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_strobe_seen", 32'(found), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_we_n", 32'(EXT_WE_n), 32'(1));
        chk("rst_mid_oe_n", 32'(EXT_OE_n), 32'(1));
        chk("rst_mid_cs2",  32'(SRAM_CS2), 32'(0));
        chk("rst_mid_ad",   32'(EXT_AD),   32'(0));
        cpu_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || vpu_ack) acks++;
        end
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || vpu_ack) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'(0));

        // Restart from IDLE after reset release
        cpu_access('{1'b0, 16'h3000, 8'h77, 5'b00000, 17'h03000, 8'h77, 1'b0}, "post_rst_wr");
        cpu_access('{1'b1, 16'h3000, 8'h00, 5'b00000, 17'h03000, 8'h77, 1'b0}, "post_rst_rd");

        chk("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
        chk("vpu_q_drained", 32'(vpu_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
